// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-requester register-bank arbiter.
// Imported by the arbiter top and by its round-robin picker.
package regfile_arb_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// On a tie, the side named by the pointer wins. The pointer register is owned by the caller.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_win
);

  always_comb begin
    o_win = i_req;
    if (i_req == 2'b11) begin
      o_win = (i_ptr == REQ_B) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that shares one register bank between requesters A and B.
// Each access runs IDLE -> ACCESS (bank cycle, grant) -> DONE (response pulse).
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rsp_valid,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              bank_sel,
  output logic              bank_wr,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata,
  output logic              busy
);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_ptr;
  logic               r_id;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rspData;
  logic [1:0]         w_win;
  logic               w_winB;
  logic               w_start;

  rr_arb2 u_rrArb (
    .i_req ({b_req, a_req}),
    .i_ptr (r_ptr),
    .o_win (w_win)
  );

  assign w_winB  = w_win[REQ_B];
  assign w_start = (r_state == IDLE) && (w_win != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= REQ_A;
      r_id      <= REQ_A;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rspData <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_start) begin
        r_id    <= w_winB;
        r_ptr   <= ~w_winB;
        r_wr    <= w_winB ? b_wr    : a_wr;
        r_addr  <= w_winB ? b_addr  : a_addr;
        r_wdata <= w_winB ? b_wdata : a_wdata;
      end
      if ((r_state == ACCESS) && !r_wr) begin
        r_rspData <= bank_rdata;
      end
    end
  end

  // bank_wr is also gated by rst so a write caught by reset never reaches the bank.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    bank_sel    = 1'b0;
    bank_wr     = 1'b0;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_nextState = ACCESS;
      end
      ACCESS: begin
        w_nextState = DONE;
        busy        = 1'b1;
        bank_sel    = 1'b1;
        bank_wr     = r_wr & ~rst;
        a_gnt       = (r_id == REQ_A);
        b_gnt       = (r_id == REQ_B);
      end
      DONE: begin
        w_nextState = IDLE;
        busy        = 1'b1;
        a_rsp_valid = (r_id == REQ_A);
        b_rsp_valid = (r_id == REQ_B);
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign bank_addr  = r_addr;
  assign bank_wdata = r_wdata;
  assign rsp_data   = r_rspData;

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one 4-entry x 16-bit register bank between two requesters, A and B.
- The bank has a `sel`/`wr`/`addr`/`wdata` port, combinational `rdata`, and writes on the clock edge.
- Arbitration is round-robin. One bank access is in flight at a time.
- The block latches the winner's operation, drives one bank cycle, and returns a response to the winner.
- It sits between the bus-side requesters and the register bank.

Parameters:
- ADDR_W, 2, bank address width.
- DATA_W, 16, bank data width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A access request.
- a_wr  in  1  A operation: 1 write, 0 read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A grant pulse.
- a_rsp_valid  out  1  A response pulse.
- b_req, b_wr, b_addr, b_wdata, b_gnt, b_rsp_valid: same as A, for requester B.
- rsp_data  out  DATA_W  read data for the current response, shared by A and B.
- bank_sel  out  1  bank select.
- bank_wr  out  1  bank write enable.
- bank_addr  out  ADDR_W  bank address.
- bank_wdata  out  DATA_W  bank write data.
- bank_rdata  in  DATA_W  bank read data, combinational from bank_sel/bank_wr/bank_addr.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Interface:
  - Single clock `clk`. Reset `rst` is synchronous and active-high.
  - All outputs are registered or decoded from registered state only.
- Reset:
  - State goes to IDLE and the round-robin pointer is set to A-priority.
  - All gnt, rsp_valid, bank_sel, bank_wr and busy are 0.
  - bank_addr, bank_wdata and rsp_data are 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples a_req and b_req. If neither is set, stays in IDLE.
  - If exactly one is set, that requester wins.
  - If both are set, the pointer side wins.
  - The pointer then moves to the loser, so the last winner gets lower priority next time.
  - At the edge, latch winner id, wr, addr and wdata, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - bank_sel=1, bank_wr=latched wr, bank_addr and bank_wdata = latched values.
  - Winner's gnt=1 for this cycle only.
  - On a read, rsp_data captures bank_rdata at the edge.
  - On a write, rsp_data holds its previous value.
  - Next state: DONE.
- DONE (exactly 1 cycle):
  - bank_sel=0, bank_wr=0.
  - Winner's rsp_valid=1, for reads and writes alike (a write response is an acknowledge).
  - rsp_data is valid only when the op was a read.
  - Next state: IDLE.
- Latency and throughput:
  - Request sampled in IDLE at cycle t gives gnt at t+1 and rsp_valid at t+2.
  - Maximum throughput is one op per 3 cycles.
- Requester protocol:
  - Hold req, wr, addr and wdata stable until gnt.
  - Deassert req no later than the DONE cycle.
  - req still high when IDLE is next sampled is a new request. This is legal back-to-back use, not an error.
  - Requester inputs are ignored in ACCESS and DONE.
- Boundary conditions:
  - Both requesting continuously: grants alternate A, B, A, B, and neither requester starves.
  - A request arriving during ACCESS/DONE waits for IDLE.
  - bank_addr and bank_wdata hold their last values when bank_sel=0.
  - Addresses are full-range. There is no wrap or range check because the bank has exactly 2^ADDR_W entries.
- Reset mid-operation:
  - The in-flight op is abandoned and no rsp_valid is issued.
  - If reset hits during ACCESS on a write, the bank write in that cycle is suppressed, because bank_wr is driven 0 during rst.

Decomposition:
- Package regfile_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - ADDR_W/DATA_W defaults;
  - requester-id constants REQ_A=0, REQ_B=1.
- Sub-module rr_arb2:
  - Combinational two-way round-robin picker.
  - Inputs: req[1:0], pointer. Outputs: one-hot win[1:0].
  - The pointer register stays in the parent FSM.

Test Plan:
- Reset, then A writes addr 2 data 16'hBEEF → a_gnt at t+1 with bank_sel=1, bank_wr=1, bank_addr=2, bank_wdata=16'hBEEF. Then a_rsp_valid at t+2 and b_* outputs stay 0.
- After that write, B reads addr 2 → b_gnt with bank_sel=1, bank_wr=0, then b_rsp_valid with rsp_data=16'hBEEF.
- A and B both request from reset, held high for 12 cycles → grant order A, B, A, B, each access 3 cycles apart.
- A reads addr 1 while B writes addr 1 = 16'h1234, simultaneous from reset → A granted first and reads the old value 16'h0000. B then writes, and a following A read returns 16'h1234.
- rst asserted during ACCESS of a B write to addr 3 = 16'h5555 → no b_rsp_valid, bank_wr=0 that cycle, busy=0 next cycle. A subsequent read of addr 3 returns 16'h0000.
- No requests for 10 cycles → busy=0, bank_sel=0 and no gnt or rsp_valid pulses.
